// File: rtl/mcpu_prog_loader_pkg.sv
`default_nettype none
// Shared MCPU sizing constants and the program-loader state encoding.
package mcpu_prog_loader_pkg;

  localparam int WORD_SIZE = 16;
  localparam int ADDR_SIZE = 8;
  localparam int RAM_SIZE  = 1 << ADDR_SIZE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HI    = 3'd1,
    ST_LO    = 3'd2,
    ST_WRITE = 3'd3,
    ST_CHK   = 3'd4,
    ST_DONE  = 3'd5
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/mcpu_prog_loader.sv
`default_nettype none
// Loads a byte stream (high byte first) into MCPU RAM, holding the CPU in reset
// until a trailing XOR checksum byte verifies the image.
module mcpu_prog_loader #(
  parameter int WORD_SIZE = mcpu_prog_loader_pkg::WORD_SIZE,
  parameter int ADDR_SIZE = mcpu_prog_loader_pkg::ADDR_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_SIZE:0]   length,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  import mcpu_prog_loader_pkg::*;

  localparam logic [ADDR_SIZE:0]   LEN_ONE = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] CNT_ONE = ADDR_SIZE'(1);

  loader_state_e          state, state_n;
  logic [ADDR_SIZE:0]     len_q, len_n;
  logic [ADDR_SIZE-1:0]   count, count_n;
  logic [7:0]             chk, chk_n;
  logic [7:0]             hi_byte, hi_n;
  logic                   in_ready_n, mem_we_n, cpu_reset_n, busy_n, done_n, error_n;
  logic [ADDR_SIZE-1:0]   mem_addr_n;
  logic [WORD_SIZE-1:0]   mem_wdata_n;
  logic                   accept;
  logic                   len_ok;

  assign accept = in_valid & in_ready;
  // Legal lengths are 1..2**ADDR_SIZE: nonzero, and the top bit only with all others clear.
  assign len_ok = (length != '0) && (!length[ADDR_SIZE] || (length[ADDR_SIZE-1:0] == '0));

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    count_n     = count;
    chk_n       = chk;
    hi_n        = hi_byte;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cpu_reset_n = cpu_reset;
    busy_n      = busy;
    done_n      = done;
    error_n     = error;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          done_n      = 1'b0;
          cpu_reset_n = 1'b1;
          if (len_ok) begin
            len_n   = length;
            count_n = '0;
            chk_n   = '0;
            error_n = 1'b0;
            busy_n  = 1'b1;
            state_n = ST_HI;
          end else begin
            error_n = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      ST_HI: begin
        if (accept) begin
          hi_n    = in_data;
          chk_n   = chk ^ in_data;
          state_n = ST_LO;
        end
      end
      ST_LO: begin
        if (accept) begin
          chk_n       = chk ^ in_data;
          mem_addr_n  = count;
          mem_wdata_n = WORD_SIZE'({hi_byte, in_data});
          state_n     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if ({1'b0, count} == (len_q - LEN_ONE)) begin
          state_n = ST_CHK;
        end else begin
          count_n = count + CNT_ONE;
          state_n = ST_HI;
        end
      end
      ST_CHK: begin
        if (accept) begin
          busy_n = 1'b0;
          if (in_data == chk) begin
            done_n      = 1'b1;
            cpu_reset_n = 1'b0;
            state_n     = ST_DONE;
          end else begin
            error_n = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // Strobes are registered from the next state so they line up with it.
    mem_we_n   = (state_n == ST_WRITE);
    in_ready_n = (state_n == ST_HI) || (state_n == ST_LO) || (state_n == ST_CHK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      count     <= '0;
      chk       <= '0;
      hi_byte   <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      count     <= count_n;
      chk       <= chk_n;
      hi_byte   <= hi_n;
      in_ready  <= in_ready_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      cpu_reset <= cpu_reset_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
    end
  end

endmodule
`default_nettype wire
